// File: rtl/scalar_mult_pkg.sv
// Shared types and fixed-point helpers for the sequential scalar-by-matrix multiplier.
// Arithmetic is done in a 64-bit signed container so one function serves every width.
package scalar_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  function automatic logic signed [63:0] sat_max(input int n_bits);
    return (64'sd1 <<< (n_bits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int n_bits);
    return -(64'sd1 <<< (n_bits - 1));
  endfunction

  function automatic logic signed [63:0] round_const(input int frac_bits);
    return 64'sd1 <<< (frac_bits - 1);
  endfunction

  localparam int N_BITS_DEF    = 22;
  localparam int FRAC_BITS_DEF = 11;
  localparam logic signed [63:0] SAT_MAX_DEF   = sat_max(N_BITS_DEF);
  localparam logic signed [63:0] SAT_MIN_DEF   = sat_min(N_BITS_DEF);
  localparam logic signed [63:0] ROUND_K_DEF   = round_const(FRAC_BITS_DEF);

  // Adding half an LSB before the arithmetic shift makes ties round toward +inf.
  function automatic sat_res_t sat_round(input logic signed [63:0] p,
                                         input int n_bits,
                                         input int frac_bits);
    sat_res_t           res;
    logic signed [63:0] r;
    r = (p + round_const(frac_bits)) >>> frac_bits;
    if (r > sat_max(n_bits)) begin
      res.sat = 1'b1;
      res.val = sat_max(n_bits);
    end else if (r < sat_min(n_bits)) begin
      res.sat = 1'b1;
      res.val = sat_min(n_bits);
    end else begin
      res.sat = 1'b0;
      res.val = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// One multiplier lane: signed product, round-half-up shift and clamp to N_BITS.
module fxp_mul_sat
  import scalar_mult_pkg::*;
#(
  parameter int N_BITS    = 22,
  parameter int FRAC_BITS = 11
) (
  input  logic signed [N_BITS-1:0] a_i,
  input  logic signed [N_BITS-1:0] b_i,
  output logic signed [N_BITS-1:0] y_o,
  output logic                     sat_o
);

  logic signed [2*N_BITS-1:0] prod;
  sat_res_t                   res;
  logic                       unused_hi;

  assign prod = a_i * b_i;

  always_comb begin
    res = sat_round(64'(prod), N_BITS, FRAC_BITS);
  end

  // Clamp guarantees the upper bits are pure sign extension.
  assign y_o       = res.val[N_BITS-1:0];
  assign sat_o     = res.sat;
  assign unused_hi = ^res.val[63:N_BITS];

endmodule

// File: rtl/scalar_multiply_mat_seq.sv
// Sequential scale-by-matrix multiplier: latches operands on start, then computes
// LANES elements per clock into a registered output matrix and pulses done.
module scalar_multiply_mat_seq
  import scalar_mult_pkg::*;
#(
  parameter int SIZE_A    = 8,
  parameter int SIZE_B    = 8,
  parameter int N_BITS    = 22,
  parameter int FRAC_BITS = 11,
  parameter int LANES     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [N_BITS-1:0] scale,
  input  logic signed [N_BITS-1:0] matrix     [SIZE_A][SIZE_B],
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag,
  output logic signed [N_BITS-1:0] out_matrix [SIZE_A][SIZE_B],
  output state_t                   dbg_state_o
);

  localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - LANES);

  if (LANES < 1 || (SIZE_B % LANES) != 0) begin : g_bad_lanes
    $error("LANES must be >= 1 and divide SIZE_B");
  end
  if (2 * N_BITS + 1 > 64) begin : g_bad_width
    $error("N_BITS too wide for the 64-bit rounding container");
  end

  // Handshake: start is sampled only in IDLE; once taken, inputs are ignored until
  // done, a single-cycle pulse after which out_matrix/sat_flag hold until next start.
  state_t                   state_q;
  logic [RW-1:0]            row_q;
  logic [CW-1:0]            col_q;
  logic signed [N_BITS-1:0] scale_q;
  logic signed [N_BITS-1:0] mat_q [SIZE_A][SIZE_B];
  logic signed [N_BITS-1:0] out_q [SIZE_A][SIZE_B];
  logic                     busy_q, done_q, sat_q;

  logic [CW-1:0]            lane_col [LANES];
  logic signed [N_BITS-1:0] lane_y   [LANES];
  logic [LANES-1:0]         lane_sat;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_col[k] = col_q + CW'(k);
    fxp_mul_sat #(
      .N_BITS   (N_BITS),
      .FRAC_BITS(FRAC_BITS)
    ) u_mul (
      .a_i  (mat_q[row_q][lane_col[k]]),
      .b_i  (scale_q),
      .y_o  (lane_y[k]),
      .sat_o(lane_sat[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      scale_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < SIZE_A; i++) begin
        for (int j = 0; j < SIZE_B; j++) begin
          mat_q[i][j] <= '0;
          out_q[i][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            scale_q <= scale;
            mat_q   <= matrix;
            sat_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < LANES; k++) begin
            out_q[row_q][lane_col[k]] <= lane_y[k];
          end
          if (|lane_sat) sat_q <= 1'b1;
          if (row_q == ROW_LAST && col_q == COL_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + CW'(LANES);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sat_flag    = sat_q;
  assign out_matrix  = out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scalar_multiply_mat_seq.sv
// Self-checking bench for scalar_multiply_mat_seq: scoreboard of expected elements,
// scenario tasks, plus a LANES sweep across extra instances.
module tb_scalar_multiply_mat_seq;
  import scalar_mult_pkg::*;

  localparam int SA = 8;
  localparam int SB = 8;
  localparam int NB = 22;
  localparam int FB = 11;

  logic                 clk, rst_n, start;
  logic signed [NB-1:0] scale;
  logic signed [NB-1:0] mat_in [SA][SB];

  logic                 busy, done, sat_flag;
  logic signed [NB-1:0] out_m [SA][SB];
  state_t               st;
  logic                 b1, d1, s1, b2, d2, s2, b8, d8, s8;
  logic signed [NB-1:0] o1 [SA][SB];
  logic signed [NB-1:0] o2 [SA][SB];
  logic signed [NB-1:0] o8 [SA][SB];
  state_t               st1, st2, st8;

  int errors = 0;
  int checks = 0;
  logic [NB-1:0] exp_q[$];
  logic          exp_sat_q[$];

  scalar_multiply_mat_seq #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB), .FRAC_BITS(FB), .LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scale(scale), .matrix(mat_in),
    .busy(busy), .done(done), .sat_flag(sat_flag), .out_matrix(out_m), .dbg_state_o(st));
  scalar_multiply_mat_seq #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB), .FRAC_BITS(FB), .LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .scale(scale), .matrix(mat_in),
    .busy(b1), .done(d1), .sat_flag(s1), .out_matrix(o1), .dbg_state_o(st1));
  scalar_multiply_mat_seq #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB), .FRAC_BITS(FB), .LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start(start), .scale(scale), .matrix(mat_in),
    .busy(b2), .done(d2), .sat_flag(s2), .out_matrix(o2), .dbg_state_o(st2));
  scalar_multiply_mat_seq #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB), .FRAC_BITS(FB), .LANES(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .start(start), .scale(scale), .matrix(mat_in),
    .busy(b8), .done(d8), .sat_flag(s8), .out_matrix(o8), .dbg_state_o(st8));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [NB-1:0] model_elem(input logic signed [NB-1:0] a,
                                               input logic signed [NB-1:0] s);
    longint p, r;
    p = longint'(a) * longint'(s);
    r = (p + 64'sd1024) >>> 11;
    if (r > 64'sd2097151) r = 64'sd2097151;
    else if (r < -64'sd2097152) r = -64'sd2097152;
    return r[NB-1:0];
  endfunction

  function automatic logic model_sat(input logic signed [NB-1:0] a,
                                     input logic signed [NB-1:0] s);
    longint p, r;
    p = longint'(a) * longint'(s);
    r = (p + 64'sd1024) >>> 11;
    return (r > 64'sd2097151) || (r < -64'sd2097152);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_identity();
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) mat_in[i][j] = NB'(8 * i + j);
  endtask

  task automatic fill_random();
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) mat_in[i][j] = NB'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic drive_op(input logic signed [NB-1:0] s);
    logic any_sat;
    any_sat = 1'b0;
    scale = s;
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) begin
        exp_q.push_back(model_elem(mat_in[i][j], s));
        any_sat = any_sat | model_sat(mat_in[i][j], s);
      end
    exp_sat_q.push_back(any_sat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
  endtask

  // Cycle 1 is the cycle right after the accepting edge. Scores the DUT at done.
  task automatic wait_done(input int glitch_cyc, output int cyc);
    int busy_bad;
    logic [NB-1:0] e;
    logic es;
    busy_bad = 0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_bad++;
      if (cyc == glitch_cyc) begin
        start = 1'b1;
        scale = ~scale;
        fill_random();
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL busy_during_run: %0d cycles low, want 0", busy_bad);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
      exp_q.delete();
      exp_sat_q.delete();
      return;
    end
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (out_m[i][j] !== e) begin
          errors++;
          $display("FAIL out_matrix[%0d][%0d]: got %0d want %0d", i, j, out_m[i][j], $signed(e));
        end
      end
    es = exp_sat_q.pop_front();
    checks++;
    if (sat_flag !== es) begin
      errors++;
      $display("FAIL sat_flag: got %b want %b", sat_flag, es);
    end
    checks++;
    if (busy !== 1'b0 || st !== DONE) begin
      errors++;
      $display("FAIL done_state: busy=%b state=%0d want busy=0 state=%0d", busy, st, DONE);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    scale = '0;
    fill_identity();
    repeat (3) @(negedge clk);
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) if (out_m[i][j] !== '0) bad++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0 || st !== IDLE) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b sat=%b state=%0d want 0 0 0 0", busy, done, sat_flag, st);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_out: %0d nonzero elements, want 0", bad);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int c;
    fill_identity();
    drive_op(22'sd2048);
    wait_done(0, c);
    checks++;
    if (c !== 17) begin
      errors++;
      $display("FAIL identity_latency: got %0d want 17", c);
    end
  endtask

  task automatic test_rounding();
    int c;
    logic signed [NB-1:0] vals [4];
    logic signed [NB-1:0] want [4];
    vals = '{22'sd3, -22'sd3, 22'sd1, -22'sd1};
    want = '{22'sd2, -22'sd1, 22'sd1, 22'sd0};
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) mat_in[i][j] = vals[j % 4];
    drive_op(22'sd1024);
    wait_done(0, c);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_m[3][k + 4] !== want[k]) begin
        errors++;
        $display("FAIL round_half_up[%0d]: got %0d want %0d", k, out_m[3][k + 4], want[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int c;
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) mat_in[i][j] = (j % 2 == 0) ? 22'sd2097151 : -22'sd2097152;
    drive_op(22'sd2097151);
    wait_done(0, c);
    checks++;
    if (out_m[0][0] !== 22'sd2097151 || out_m[0][1] !== -22'sd2097152) begin
      errors++;
      $display("FAIL sat_clamp: got %0d %0d want 2097151 -2097152", out_m[0][0], out_m[0][1]);
    end
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) mat_in[i][j] = NB'($urandom_range(0, 200000)) - 22'sd100000;
    drive_op(22'sd2048);
    wait_done(0, c);
  endtask

  task automatic test_random();
    int c;
    for (int n = 0; n < 3; n++) begin
      fill_random();
      drive_op(NB'($urandom_range(0, 8191)) - 22'sd4096);
      wait_done(0, c);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < SA; i++)
        for (int j = 0; j < SB; j++) mat_in[i][j] = NB'($urandom_range(0, 60000)) - 22'sd30000;
      drive_op(NB'($urandom_range(1, 6000)));
      wait_done(0, c);
      checks++;
      if (c !== 17) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: got %0d want 17", n, c);
      end
    end
  endtask

  task automatic test_start_in_run();
    int c, extra;
    fill_random();
    drive_op(22'sd3000);
    wait_done(3, c);
    extra = 0;
    repeat (20) begin
      if (done === 1'b1 || busy === 1'b1) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL start_not_queued: %0d active cycles after done, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad, n_done, c;
    fill_random();
    drive_op(22'sd1500);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_sat_q.delete();
    bad = 0;
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) if (out_m[i][j] !== '0) bad++;
    checks++;
    if (bad != 0 || busy !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0 || st !== IDLE) begin
      errors++;
      $display("FAIL abort_reset: nonzero=%0d busy=%b done=%b sat=%b state=%0d want all 0", bad, busy, done, sat_flag, st);
    end
    n_done = 0;
    repeat (20) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", n_done);
    end
    fill_identity();
    drive_op(22'sd2048);
    wait_done(0, c);
  endtask

  task automatic test_lanes_sweep();
    int c, dc4, dc1, dc2, dc8;
    logic signed [NB-1:0] e;
    repeat (80) @(negedge clk);
    fill_identity();
    scale = 22'sd2048;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1; dc4 = 0; dc1 = 0; dc2 = 0; dc8 = 0;
    while (c < 120 && (dc4 == 0 || dc1 == 0 || dc2 == 0 || dc8 == 0)) begin
      if (done === 1'b1 && dc4 == 0) dc4 = c;
      if (d1 === 1'b1 && dc1 == 0) dc1 = c;
      if (d2 === 1'b1 && dc2 == 0) dc2 = c;
      if (d8 === 1'b1 && dc8 == 0) dc8 = c;
      @(negedge clk);
      c++;
    end
    checks++;
    if (dc4 != 17 || dc1 != 65 || dc2 != 33 || dc8 != 9) begin
      errors++;
      $display("FAIL lanes_latency: got L4=%0d L1=%0d L2=%0d L8=%0d want 17 65 33 9", dc4, dc1, dc2, dc8);
    end
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++) begin
        e = NB'(8 * i + j);
        checks++;
        if (out_m[i][j] !== e || o1[i][j] !== e || o2[i][j] !== e || o8[i][j] !== e) begin
          errors++;
          $display("FAIL lanes_result[%0d][%0d]: got %0d %0d %0d %0d want %0d", i, j,
                   out_m[i][j], o1[i][j], o2[i][j], o8[i][j], e);
        end
      end
    checks++;
    if (sat_flag !== 1'b0 || s1 !== 1'b0 || s2 !== 1'b0 || s8 !== 1'b0) begin
      errors++;
      $display("FAIL lanes_sat: got %b%b%b%b want 0000", sat_flag, s1, s2, s8);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_identity();
    test_rounding();
    test_saturation();
    test_random();
    test_back_to_back();
    test_start_in_run();
    test_reset_mid_run();
    test_lanes_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
